// File: rtl/data_ram_responder.sv
// Data-RAM responder: one word load/store per req/ready handshake, fixed wait states.
// Define DRAM_ALIGN_CHECK_EN to flag misaligned accesses on err and suppress them.
module data_ram_responder #(
   parameter int AW          = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic [31:0] rdata,
   output logic        err
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
   localparam logic [3:0] CNT_INIT =
      ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_we;
   logic [AW-1:0] r_idx;
   logic [31:0] r_wdata;
   logic        r_ready;
   logic [31:0] r_rdata;
   logic [31:0] r_mem [2**AW];

   logic        w_go;
   logic        w_s_we;
   logic [AW-1:0] w_s_idx;
   logic        w_s_mis;
   logic        w_commit;
   logic        w_unused;

   // With zero wait states the response is formed straight from the port.
   assign w_go = (r_state == S_IDLE && req && ZERO_WAIT) ||
                 (r_state == S_WAIT && r_cnt == 4'd0);
   assign w_s_we  = (r_state == S_IDLE) ? we : r_we;
   assign w_s_idx = (r_state == S_IDLE) ? addr[AW+1:2] : r_idx;
   assign w_unused = ^{addr[31:AW+2], addr[1:0]};

`ifdef DRAM_ALIGN_CHECK_EN
   logic r_mis;
   logic r_err;
   assign w_s_mis  = (r_state == S_IDLE) ? (addr[1:0] != 2'b00) : r_mis;
   assign w_commit = r_we && !r_mis;
   assign err      = r_err;
`else
   assign w_s_mis  = 1'b0;
   assign w_commit = r_we;
   assign err      = 1'b0;
`endif

   assign ready = r_ready;
   assign rdata = r_rdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_we    <= 1'b0;
         r_idx   <= '0;
         r_wdata <= 32'd0;
         r_ready <= 1'b0;
         r_rdata <= 32'd0;
`ifdef DRAM_ALIGN_CHECK_EN
         r_mis   <= 1'b0;
         r_err   <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (req) begin
                  r_we    <= we;
                  r_idx   <= addr[AW+1:2];
                  r_wdata <= wdata;
`ifdef DRAM_ALIGN_CHECK_EN
                  r_mis   <= (addr[1:0] != 2'b00);
`endif
                  if (ZERO_WAIT) begin
                     r_state <= S_RESP;
                  end else begin
                     r_state <= S_WAIT;
                     r_cnt   <= CNT_INIT;
                  end
               end
            end
            S_WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_state <= S_RESP;
               end else begin
                  r_cnt <= 4'(r_cnt - 4'd1);
               end
            end
            S_RESP: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase

         if (w_go) begin
            r_ready <= 1'b1;
`ifdef DRAM_ALIGN_CHECK_EN
            r_err   <= w_s_mis;
`endif
            if (!w_s_we) begin
               r_rdata <= w_s_mis ? 32'd0 : r_mem[w_s_idx];
            end
         end else begin
            r_ready <= 1'b0;
         end
      end
   end

   // Store commits on the edge leaving RESP; a reset here drops it.
   always_ff @(posedge clk) begin
      if (!rst && r_state == S_RESP && w_commit) begin
         r_mem[r_idx] <= r_wdata;
      end
   end

endmodule

// File: tb/tb_data_ram_responder.sv
// Scoreboard bench: DUT A with 2 wait states, DUT B with 0 wait states.
// Expectations follow DRAM_ALIGN_CHECK_EN when it is defined for the build.
module tb_data_ram_responder;

   localparam int AW = 10;
`ifdef DRAM_ALIGN_CHECK_EN
   localparam bit ALN = 1'b1;
`else
   localparam bit ALN = 1'b0;
`endif

   typedef struct {
      logic        we;
      logic [31:0] rd;
      logic        er;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, req_a, we_a, ready_a, err_a;
   logic [31:0] addr_a, wdata_a, rdata_a;
   logic        rst_b, req_b, we_b, ready_b, err_b;
   logic [31:0] addr_b, wdata_b, rdata_b;

   exp_t sb_a[$];
   exp_t sb_b[$];
   exp_t ea, eb;
   int   n_tests = 0;
   int   n_fail  = 0;

   data_ram_responder #(.AW(AW), .WAIT_CYCLES(2)) u_dut_a (
      .clk(clk), .rst(rst_a), .req(req_a), .we(we_a),
      .addr(addr_a), .wdata(wdata_a),
      .ready(ready_a), .rdata(rdata_a), .err(err_a)
   );

   data_ram_responder #(.AW(AW), .WAIT_CYCLES(0)) u_dut_b (
      .clk(clk), .rst(rst_b), .req(req_b), .we(we_b),
      .addr(addr_b), .wdata(wdata_b),
      .ready(ready_b), .rdata(rdata_b), .err(err_b)
   );

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic w, input logic [31:0] a,
                               input logic [31:0] rd);
      exp_t e;
      e.we = w;
      e.er = ALN && (a[1:0] != 2'b00);
      e.rd = e.er ? 32'd0 : rd;
      return e;
   endfunction

   always @(negedge clk) begin
      if (ready_a) begin
         check("a_pending", 32'(sb_a.size() != 0), 32'd1);
         if (sb_a.size() != 0) begin
            ea = sb_a.pop_front();
            check("a_err", 32'(err_a), 32'(ea.er));
            if (!ea.we) check("a_rdata", rdata_a, ea.rd);
         end
      end
      if (ready_b) begin
         check("b_pending", 32'(sb_b.size() != 0), 32'd1);
         if (sb_b.size() != 0) begin
            eb = sb_b.pop_front();
            check("b_err", 32'(err_b), 32'(eb.er));
            if (!eb.we) check("b_rdata", rdata_b, eb.rd);
         end
      end
   end

   task automatic xfer(input bit b, input logic w,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] rd, input bit drop);
      int n;
      int wc;
      wc = b ? 0 : 2;
      @(negedge clk);
      if (b) begin
         req_b = 1'b1; we_b = w; addr_b = a; wdata_b = d;
         sb_b.push_back(mk(w, a, rd));
      end else begin
         req_a = 1'b1; we_a = w; addr_a = a; wdata_a = d;
         sb_a.push_back(mk(w, a, rd));
      end
      @(posedge clk);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (drop && n == 1 && !b) begin
            req_a = 1'b0; we_a = ~w; addr_a = ~a; wdata_a = ~d;
         end
      end while (!(b ? ready_b : ready_a) && n < 40);
      check(b ? "lat_b" : "lat_a", 32'(n), 32'(wc + 1));
      if (b) req_b = 1'b0;
      else   req_a = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_a = 1'b1; req_a = 1'b0; we_a = 1'b0;
      addr_a = 32'd0; wdata_a = 32'd0;
      rst_b = 1'b1; req_b = 1'b0; we_b = 1'b0;
      addr_b = 32'd0; wdata_b = 32'd0;
      repeat (2) @(negedge clk);
      rst_a = 1'b0; rst_b = 1'b0;
      @(negedge clk);
      check("rst_ready_a", 32'(ready_a), 32'd0);
      check("rst_rdata_a", rdata_a, 32'd0);
      check("rst_err_a", 32'(err_a), 32'd0);
      check("rst_ready_b", 32'(ready_b), 32'd0);
      check("rst_rdata_b", rdata_b, 32'd0);

      xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'd0, 0);
      xfer(0, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 0);

      xfer(0, 1'b1, 32'((1 << (AW + 2)) + 4), 32'h12345678, 32'd0, 0);
      xfer(0, 1'b0, 32'h4, 32'd0, 32'h12345678, 0);

      // Abort a store mid-wait; the old word must survive.
      xfer(0, 1'b1, 32'h20, 32'h11111111, 32'd0, 0);
      @(negedge clk);
      req_a = 1'b1; we_a = 1'b1; addr_a = 32'h20; wdata_a = 32'hAAAA5555;
      @(posedge clk);
      @(negedge clk);
      req_a = 1'b0; rst_a = 1'b1;
      @(negedge clk);
      rst_a = 1'b0;
      n = 0;
      repeat (5) begin
         @(negedge clk);
         if (ready_a) n++;
      end
      check("abort_noready", 32'(n), 32'd0);
      check("abort_rdata", rdata_a, 32'd0);
      xfer(0, 1'b0, 32'h20, 32'd0, 32'h11111111, 0);

      xfer(0, 1'b1, 32'h22, 32'h77777777, 32'd0, 0);
      xfer(0, 1'b0, 32'h20, 32'd0, ALN ? 32'h11111111 : 32'h77777777, 0);
      xfer(0, 1'b0, 32'h21, 32'd0, ALN ? 32'h11111111 : 32'h77777777, 0);

      xfer(0, 1'b1, 32'h30, 32'h5A5A0001, 32'd0, 1);
      xfer(0, 1'b0, 32'h30, 32'd0, 32'h5A5A0001, 0);
      xfer(0, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1);
      xfer(0, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 0);

      // Zero-wait DUT: array survives reset, then back-to-back with req held.
      xfer(1, 1'b1, 32'h0, 32'h0BADF00D, 32'd0, 0);
      @(negedge clk); rst_b = 1'b1;
      @(negedge clk); rst_b = 1'b0;
      xfer(1, 1'b0, 32'h0, 32'd0, 32'h0BADF00D, 0);

      @(negedge clk);
      req_b = 1'b1; we_b = 1'b1; addr_b = 32'h40; wdata_b = 32'hCAFEF00D;
      sb_b.push_back(mk(1'b1, 32'h40, 32'd0));
      sb_b.push_back(mk(1'b0, 32'h40, 32'hCAFEF00D));
      n = 0;
      do begin @(negedge clk); n++; end while (!ready_b && n < 10);
      check("b2b_lat1", 32'(n), 32'd1);
      we_b = 1'b0; wdata_b = 32'd0;
      @(negedge clk);
      check("b2b_gap", 32'(ready_b), 32'd0);
      n = 0;
      do begin @(negedge clk); n++; end while (!ready_b && n < 10);
      check("b2b_lat2", 32'(n), 32'd1);
      req_b = 1'b0;

      repeat (3) @(negedge clk);
      check("sb_a_drained", 32'(sb_a.size()), 32'd0);
      check("sb_b_drained", 32'(sb_b.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
